// File: rtl/uart_io_device_pkg.sv
// ============================================================================
// Module  : uart_io_device_pkg
// Brief   : Register map, STATUS bit positions and FSM state types for the
//           memory-mapped UART.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package uart_io_device_pkg;

  localparam logic [31:0] c_status_ofs = 32'h0;
  localparam logic [31:0] c_rx_ofs     = 32'h4;
  localparam logic [31:0] c_tx_ofs     = 32'h8;

  localparam int c_bit_tx_ready  = 0;
  localparam int c_bit_rx_avail  = 1;
  localparam int c_bit_overrun   = 2;
  localparam int c_bit_frame_err = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic tx_ready, input logic rx_avail,
                                              input logic overrun, input logic frame_err);
    logic [31:0] w;
    w = '0;
    w[c_bit_tx_ready]  = tx_ready;
    w[c_bit_rx_avail]  = rx_avail;
    w[c_bit_overrun]   = overrun;
    w[c_bit_frame_err] = frame_err;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_io_device_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with wrap-bit pointers; a pop in the same cycle
//           frees a slot for a push into a full FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enqueue,
  input  logic             dequeue,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_enq;
  logic               w_do_deq;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_deq = dequeue && !empty;
  assign w_do_enq = enqueue && (!full || w_do_deq);
  assign value_o  = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr[c_aw-1:0]] <= value_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_io_device.sv
// ============================================================================
// Module  : uart_io_device
// Brief   : Memory-mapped 8N1 UART: STATUS / RX_DATA / TX_DATA registers,
//           transmit serializer and receive deserializer feeding a FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_io_device
  import uart_io_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h40,
  parameter int          CLOCKS_PER_BIT = 434,
  parameter int          RX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int              c_cw        = $clog2(CLOCKS_PER_BIT);
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLOCKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(CLOCKS_PER_BIT / 2 - 1);

  // ---------------- register decode ----------------
  logic w_rd_status, w_rd_rx, w_rd_tx, w_wr_tx;
  logic w_unused_wdata;

  assign w_rd_status    = io_read_en  && (io_address == BASE_ADDRESS + c_status_ofs);
  assign w_rd_rx        = io_read_en  && (io_address == BASE_ADDRESS + c_rx_ofs);
  assign w_rd_tx        = io_read_en  && (io_address == BASE_ADDRESS + c_tx_ofs);
  assign w_wr_tx        = io_write_en && (io_address == BASE_ADDRESS + c_tx_ofs);
  assign w_unused_wdata = &{1'b0, io_write_data[31:8]};

  // ---------------- transmitter ----------------
  tx_state_t       r_tx_state, w_tx_state_nxt;
  logic [c_cw-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [7:0]      r_tx_shift, w_tx_shift_nxt;
  logic [2:0]      r_tx_bit, w_tx_bit_nxt;
  logic            r_uart_tx, w_uart_tx_nxt;
  logic            w_tx_bit_done;

  assign w_tx_bit_done = (r_tx_cnt == c_bit_last);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + c_cw'(1);
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_uart_tx_nxt  = r_uart_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_uart_tx_nxt = 1'b1;
        w_tx_cnt_nxt  = '0;
        if (w_wr_tx) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = io_write_data[7:0];
          w_uart_tx_nxt  = 1'b0;
        end
      end
      TX_START: if (w_tx_bit_done) begin
        w_tx_state_nxt = TX_DATA;
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = 3'd0;
        w_uart_tx_nxt  = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_done) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_bit == 3'd7) begin
          w_tx_state_nxt = TX_STOP;
          w_uart_tx_nxt  = 1'b1;
        end else begin
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_uart_tx_nxt  = r_tx_shift[1];
        end
      end
      TX_STOP: if (w_tx_bit_done) begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = '0;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_uart_tx  <= w_uart_tx_nxt;
    end
  end

  assign uart_tx = r_uart_tx;

  // ---------------- receiver ----------------
  rx_state_t       r_rx_state, w_rx_state_nxt;
  logic [c_cw-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [7:0]      r_rx_shift, w_rx_shift_nxt;
  logic [2:0]      r_rx_bit, w_rx_bit_nxt;
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic            w_push, w_frame_set;

  // Samples land mid-bit: half a bit after the falling edge, then every full bit.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + c_cw'(1);
    w_rx_shift_nxt = r_rx_shift;
    w_rx_bit_nxt   = r_rx_bit;
    w_push         = 1'b0;
    w_frame_set    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
      end
      RX_START: if (r_rx_cnt == c_half_last) begin
        w_rx_cnt_nxt   = '0;
        w_rx_bit_nxt   = 3'd0;
        w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == c_bit_last) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
        w_rx_bit_nxt   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == c_bit_last) begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = RX_IDLE;
        w_push         = r_rx_sync;
        w_frame_set    = !r_rx_sync;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0] w_fifo_dout;
  logic       w_fifo_full, w_fifo_empty, w_pop;

  assign w_pop = w_rd_rx && !w_fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .enqueue (w_push),
    .dequeue (w_pop),
    .value_i (w_rx_shift_nxt),
    .value_o (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // ---------------- status and read data ----------------
  logic        r_overrun, r_frame_err;
  logic [31:0] r_read_data;
  logic        w_overrun_set;

  assign w_overrun_set = w_push && w_fifo_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_overrun   <= (r_overrun   && !w_rd_status) || w_overrun_set;
      r_frame_err <= (r_frame_err && !w_rd_status) || w_frame_set;
      if (w_rd_status)
        r_read_data <= status_word(r_tx_state == TX_IDLE, !w_fifo_empty, r_overrun, r_frame_err);
      else if (w_rd_rx)
        r_read_data <= w_fifo_empty ? 32'h0 : {24'h0, w_fifo_dout};
      else if (w_rd_tx)
        r_read_data <= 32'h0;
    end
  end

  assign io_read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_io_device.sv
// ============================================================================
// Module  : tb_uart_io_device
// Brief   : Directed self-checking bench for uart_io_device (8 clk/bit, 4-deep FIFO).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_io_device;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_write_en, io_read_en;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic        uart_tx, uart_rx;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_ST = 32'h40;
  localparam logic [31:0] A_RX = 32'h44;
  localparam logic [31:0] A_TX = 32'h48;

  always #5 clk = ~clk;

  uart_io_device #(
    .BASE_ADDRESS   (32'h40),
    .CLOCKS_PER_BIT (8),
    .RX_FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_read_en = 1'b1;
    io_address = a;
    tick();
    io_read_en = 1'b0;
    io_address = 32'h0;
    d = io_read_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    io_write_en   = 1'b1;
    io_address    = a;
    io_write_data = v;
    tick();
    io_write_en   = 1'b0;
    io_address    = 32'h0;
  endtask

  // Frame cycle k: bit k/8 of {stop, data, start}; the receiver pushes at the
  // end of cycle 78, so an RX_DATA read strobed in that cycle coincides with it.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit rd_mid,
                           output logic [31:0] rd_val);
    logic [9:0] frame;
    frame  = {stop, b, 1'b0};
    rd_val = 32'h0;
    for (int k = 0; k < 84; k++) begin
      uart_rx = (k < 80) ? frame[k/8] : 1'b1;
      if (rd_mid && k == 78) begin
        io_read_en = 1'b1;
        io_address = A_RX;
      end
      if (rd_mid && k == 79) begin
        io_read_en = 1'b0;
        io_address = 32'h0;
        rd_val     = io_read_data;
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  txf;
    int          good[10];

    vecs[0]  = '{1'b0, 32'h40,   32'h0,  32'h1, 1'b1};
    vecs[1]  = '{1'b0, 32'h3C,   32'h0,  32'h1, 1'b1};
    vecs[2]  = '{1'b0, 32'h44,   32'h0,  32'h0, 1'b1};
    vecs[3]  = '{1'b0, 32'h4C,   32'h0,  32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h40,   32'h0,  32'h1, 1'b1};
    vecs[5]  = '{1'b0, 32'h41,   32'h0,  32'h1, 1'b1};
    vecs[6]  = '{1'b1, 32'h40,   32'hFF, 32'h1, 1'b1};
    vecs[7]  = '{1'b1, 32'h44,   32'hAA, 32'h1, 1'b1};
    vecs[8]  = '{1'b1, 32'h148,  32'h55, 32'h1, 1'b1};
    vecs[9]  = '{1'b0, 32'h44,   32'h0,  32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h40,   32'h0,  32'h1, 1'b1};
    vecs[11] = '{1'b0, 32'h1044, 32'h0,  32'h1, 1'b1};

    reset = 1'b1; io_write_en = 1'b0; io_read_en = 1'b0;
    io_address = 32'h0; io_write_data = 32'h0; uart_rx = 1'b1;
    repeat (3) begin
      tick();
      check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    end
    check("reset_read_data", io_read_data, 32'h0);
    reset = 1'b0;
    tick();

    // Register decode vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].wdata);
      else               rd(vecs[i].addr, d);
      check($sformatf("vec%0d_read_data", i), io_read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_uart_tx", i), {31'b0, uart_tx}, {31'b0, vecs[i].exp_tx});
    end

    // Transmit 0xA5, dropped second write, busy status
    wr(A_TX, 32'hA5);
    txf = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) good[b] = 0;
    for (int k = 0; k < 80; k++) begin
      if (uart_tx === txf[k/8]) good[k/8]++;
      io_write_en = 1'b0;
      io_read_en  = 1'b0;
      io_address  = 32'h0;
      if (k == 10) begin
        io_write_en = 1'b1; io_address = A_TX; io_write_data = 32'hFF;
      end
      if (k == 21) check("status_busy", io_read_data, 32'h0);
      if (k == 20 || k == 79) begin
        io_read_en = 1'b1; io_address = A_ST;
      end
      tick();
    end
    io_read_en = 1'b0; io_address = 32'h0;
    check("status_last_stop_cycle", io_read_data, 32'h0);
    for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_cycles", b), good[b], 32'd8);
    check("tx_idle_after_frame", {31'b0, uart_tx}, 32'h1);
    rd(A_ST, d); check("status_ready_after_stop", d, 32'h1);

    // Single byte receive
    send_byte(8'h3C, 1'b1, 1'b0, d);
    rd(A_ST, d); check("status_rx_avail", d, 32'h3);
    rd(A_RX, d); check("rx_data_3c", d, 32'h3C);
    rd(A_ST, d); check("status_after_pop", d, 32'h1);

    // Overrun: five bytes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0, d);
    rd(A_ST, d); check("status_overrun", d, 32'h7);
    for (int i = 1; i <= 4; i++) begin
      rd(A_RX, d); check($sformatf("rx_fifo_%0d", i), d, 32'(i));
    end
    rd(A_RX, d); check("rx_empty_read", d, 32'h0);
    rd(A_ST, d); check("status_overrun_cleared", d, 32'h1);

    // Framing error, then a short glitch
    send_byte(8'h55, 1'b0, 1'b0, d);
    rd(A_ST, d); check("status_frame_err", d, 32'h9);
    rd(A_RX, d); check("rx_after_frame_err", d, 32'h0);
    rd(A_ST, d); check("status_frame_err_cleared", d, 32'h1);
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (100) tick();
    rd(A_ST, d); check("status_after_glitch", d, 32'h1);
    rd(A_RX, d); check("rx_after_glitch", d, 32'h0);

    // Full FIFO with a pop coinciding with a push
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0, d);
    send_byte(8'h14, 1'b1, 1'b1, d);
    check("coincident_pop_data", d, 32'h10);
    rd(A_ST, d); check("status_no_overrun", d, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      rd(A_RX, d); check($sformatf("rx_after_coincide_%0d", i), d, 32'h10 + 32'(i));
    end
    rd(A_RX, d); check("rx_empty_after_coincide", d, 32'h0);

    // Reset during transmission
    wr(A_TX, 32'h00);
    repeat (20) tick();
    check("tx_low_before_reset", {31'b0, uart_tx}, 32'h0);
    reset = 1'b1;
    tick();
    check("tx_high_after_reset", {31'b0, uart_tx}, 32'h1);
    reset = 1'b0;
    tick();
    rd(A_ST, d); check("status_after_tx_reset", d, 32'h1);

    // Reset during reception discards the partial byte
    uart_rx = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    uart_rx = 1'b1;
    repeat (100) tick();
    rd(A_ST, d); check("status_after_rx_reset", d, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
